// File: rtl/read_first_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// read_first_fifo_ctrl : valid/ready FIFO around an external 1-cycle registered
//                        read-first dual-port RAM, with a 2-entry output buffer
// Revision: 1.0
// ============================================================================
module read_first_fifo_ctrl #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ADDRESS_WIDTH+1:0] level,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
  logic [ADDRESS_WIDTH:0]   r_ram_count;
  logic                     r_rd_pend;
  logic [DATA_WIDTH-1:0]    r_obuf0;
  logic [DATA_WIDTH-1:0]    r_obuf1;
  logic [1:0]               r_obuf_count;
  logic [ADDRESS_WIDTH+1:0] r_level;
  logic                     r_in_ready;
  logic                     r_out_valid;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_issue;
  logic [2:0]               w_obuf_load;
  logic [ADDRESS_WIDTH:0]   w_ram_count_next;
  logic [DATA_WIDTH-1:0]    w_obuf0_next;
  logic [DATA_WIDTH-1:0]    w_obuf1_next;
  logic [1:0]               w_obuf_count_next;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // Occupancy the output buffer will have once the pending read lands and
  // this cycle's pop leaves; a new read may only be issued if a slot remains.
  assign w_obuf_load      = {1'b0, r_obuf_count} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_issue          = (r_ram_count != '0) && (w_obuf_load <= 3'd1);
  assign w_ram_count_next = r_ram_count + (ADDRESS_WIDTH+1)'(w_push)
                                        - (ADDRESS_WIDTH+1)'(w_issue);

  always_comb begin
    w_obuf0_next      = r_obuf0;
    w_obuf1_next      = r_obuf1;
    w_obuf_count_next = r_obuf_count;
    case ({w_pop, r_rd_pend})
      2'b10: begin
        w_obuf0_next      = r_obuf1;
        w_obuf_count_next = r_obuf_count - 2'd1;
      end
      2'b01: begin
        if (r_obuf_count == 2'd0) w_obuf0_next = ram_dout;
        else                      w_obuf1_next = ram_dout;
        w_obuf_count_next = r_obuf_count + 2'd1;
      end
      2'b11: begin
        if (r_obuf_count == 2'd1) begin
          w_obuf0_next = ram_dout;
        end else begin
          w_obuf0_next = r_obuf1;
          w_obuf1_next = ram_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_count  <= '0;
      r_rd_pend    <= 1'b0;
      r_obuf0      <= '0;
      r_obuf1      <= '0;
      r_obuf_count <= 2'd0;
      r_level      <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + ADDRESS_WIDTH'(1);
      r_ram_count  <= w_ram_count_next;
      r_rd_pend    <= w_issue;
      r_obuf0      <= w_obuf0_next;
      r_obuf1      <= w_obuf1_next;
      r_obuf_count <= w_obuf_count_next;
      r_level      <= r_level + (ADDRESS_WIDTH+2)'(w_push) - (ADDRESS_WIDTH+2)'(w_pop);
      // The count never exceeds DEPTH, so its MSB alone flags a full RAM.
      r_in_ready   <= ~w_ram_count_next[ADDRESS_WIDTH];
      r_out_valid  <= (w_obuf_count_next != 2'd0);
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_obuf0;
  assign level      = r_level;
  assign ram_we     = w_push;
  assign ram_addr_a = r_wr_ptr;
  assign ram_din    = in_data;
  assign ram_addr_b = r_rd_ptr;

endmodule
`default_nettype wire

// File: tb/tb_read_first_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_read_first_fifo_ctrl : bench with RAM model, queue-based reference and
//                           directed scenarios for read_first_fifo_ctrl
// Revision: 1.0
// ============================================================================
module tb_read_first_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW+1:0] level;
  logic          ram_we;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  read_first_fifo_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_we(ram_we), .ram_addr_a(ram_addr_a), .ram_din(ram_din),
    .ram_addr_b(ram_addr_b), .ram_dout(ram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External read-first RAM: read returns the pre-write contents.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
    ram_dout = 8'hEE;
  end
  always @(posedge clock) begin
    ram_dout <= mem[ram_addr_b];
    if (ram_we) mem[ram_addr_a] <= ram_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a word accepted in cycle c is presentable from cycle c+3 and
  // leaves strictly in order; level is accepted minus popped.
  initial begin : monitor
    logic [DW-1:0] mq[$];
    int            ma[$];
    int            cyc;
    bit            mon_en, post_rst, have_prev, prev_ov, prev_or, exp_ov;
    logic [DW-1:0] prev_od;
    cyc = 0; mon_en = 0; post_rst = 0; have_prev = 0;
    prev_ov = 0; prev_or = 0; prev_od = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        mq.delete();
        ma.delete();
        post_rst  = 1;
        mon_en    = 1;
        have_prev = 0;
      end else if (mon_en) begin
        if (post_rst) begin
          chk("m_rst_in_ready", 32'(in_ready), 32'd0);
          chk("m_rst_out_data", 32'(out_data), 32'd0);
          post_rst = 0;
        end
        chk("m_level", 32'(level), 32'(mq.size()));
        exp_ov = (mq.size() > 0) && (cyc >= ma[0] + 3);
        chk("m_out_valid", 32'(out_valid), 32'(exp_ov));
        if (out_valid && mq.size() > 0) chk("m_out_data", 32'(out_data), 32'(mq[0]));
        if (have_prev && prev_ov && !prev_or) chk("m_hold", 32'(out_data), 32'(prev_od));
        chk("m_ram_we", 32'(ram_we), 32'(in_valid && in_ready));
        if (ram_we) chk("m_ram_din", 32'(ram_din), 32'(in_data));
        if (mq.size() == DEPTH + 2) chk("m_full_in_ready", 32'(in_ready), 32'd0);
        if (in_valid && in_ready) begin
          mq.push_back(in_data);
          ma.push_back(cyc);
        end
        if (out_valid && out_ready && mq.size() > 0) begin
          void'(mq.pop_front());
          void'(ma.pop_front());
        end
        prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
        have_prev = 1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    step();
    chk("rst_ready_rise", 32'(in_ready), 32'd1);
  endtask

  initial begin : stimulus
    int  acc, n, exp, sent, recv;
    bit  got;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Order and latency
    do_reset();
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_data = 8'h33;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data0", 32'(out_data), 32'h11);
    chk("lat_level", 32'(level), 32'd3);
    out_ready = 1'b1; step();
    chk("ord_data1", 32'(out_data), 32'h22);
    step();
    chk("ord_data2", 32'(out_data), 32'h33);
    step();
    out_ready = 1'b0;
    chk("ord_empty_valid", 32'(out_valid), 32'd0);
    chk("ord_empty_level", 32'(level), 32'd0);

    // Fill to capacity, then one pop at the full boundary
    do_reset();
    acc = 0;
    for (int i = 1; i <= 30; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("fill_accepted", 32'(acc), 32'd18);
    chk("fill_level", 32'(level), 32'd18);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    chk("bnd_head", 32'(out_data), 32'd1);
    step();
    out_ready = 1'b0;
    got = 0;
    for (int k = 0; k < 2 && !got; k++) begin
      if (in_ready) got = 1;
      else step();
    end
    if (!got && in_ready) got = 1;
    chk("bnd_ready_back", 32'(got), 32'd1);
    in_valid = 1'b1; in_data = 8'd31; step();
    in_valid = 1'b0; step();
    chk("bnd_level", 32'(level), 32'd18);
    out_ready = 1'b1; exp = 2; n = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        chk("bnd_drain", 32'(out_data), 32'(exp));
        n++;
        exp = (exp == 18) ? 31 : exp + 1;
      end
      step();
    end
    out_ready = 1'b0;
    chk("bnd_drain_count", 32'(n), 32'd18);

    // Streaming at full rate
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      if (i >= 3) begin
        chk("str_valid", 32'(out_valid), 32'd1);
        chk("str_data", 32'(out_data), 32'(i - 3));
        chk("str_level", 32'(level), 32'd3);
      end
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    out_ready = 1'b0;
    chk("str_drained", 32'(level), 32'd0);

    // Random valid/ready with pointer wrap
    do_reset();
    sent = 0; recv = 0;
    for (int t = 0; t < 6000 && recv < 200; t++) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      in_data   = 8'(sent);
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        chk("rnd_order", 32'(out_data), 32'(recv & 8'hFF));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_count", 32'(recv), 32'd200);

    // Reset in the middle of operation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h51 + i); step();
    end
    in_valid = 1'b0;
    chk("mid_level", 32'(level), 32'd5);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_level0", 32'(level), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("mid_ready_rise", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'hAA; step();
    in_valid = 1'b0; step();
    chk("mid_not_yet", 32'(out_valid), 32'd0);
    step();
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_data", 32'(out_data), 32'hAA);
    out_ready = 1'b1; step();
    for (int k = 0; k < 4; k++) begin
      chk("mid_no_stale", 32'(out_valid), 32'd0);
      step();
    end
    out_ready = 1'b0;
    chk("mid_level_end", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
